user_stream_endpoint: RTL and testbench

//  User-side counterpart of the leaf interface's ap_vld/ap_ack stream ports, clocked on clk_user.

---
 rtl/user_stream_endpoint.sv | 103 ++++++++++
 tb/tb_user_stream_endpoint.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/user_stream_endpoint.sv
// User-side stream endpoint: accepts words from the interface, buffers them in a
// first-word-fall-through FIFO, optionally adds a constant, and streams them back.
module user_stream_endpoint #(
  parameter int unsigned PAYLOAD_BITS   = 32,
  parameter int unsigned FIFO_ADDR_BITS = 4,
  parameter int unsigned OP_MODE        = 0,
  parameter int unsigned ADD_VAL        = 1
) (
  input  logic                      clk_user,
  input  logic                      reset_n,
  input  logic [PAYLOAD_BITS-1:0]   din,
  input  logic                      din_vld,
  output logic                      din_ack,
  output logic [PAYLOAD_BITS-1:0]   dout,
  output logic                      dout_vld,
  input  logic                      dout_ack,
  output logic [31:0]               rx_count,
  output logic [31:0]               tx_count,
  output logic [FIFO_ADDR_BITS:0]   occupancy
);

  localparam int unsigned DEPTH = 2 ** FIFO_ADDR_BITS;
  localparam int unsigned OCC_W = FIFO_ADDR_BITS + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE = FIFO_ADDR_BITS'(1);

  logic [PAYLOAD_BITS-1:0]   mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr;

  logic                      push;
  logic                      pop;
  logic                      bypass;
  logic [PAYLOAD_BITS-1:0]   wdata;
  logic [OCC_W-1:0]          occ_nxt;
  logic [FIFO_ADDR_BITS-1:0] rd_nxt;
  logic [PAYLOAD_BITS-1:0]   head_nxt;

  // Accept is a function of the occupancy register only; forced low while in reset.
  assign din_ack = reset_n & (occupancy != OCC_FULL);

  // Next-state of the FIFO and the word that will sit at its head after this edge.
  always_comb begin
    push     = din_vld & din_ack;
    pop      = dout_vld & dout_ack;
    wdata    = (OP_MODE == 1) ? (din + PAYLOAD_BITS'(ADD_VAL)) : din;
    occ_nxt  = occupancy;
    rd_nxt   = rd_ptr;
    bypass   = 1'b0;
    head_nxt = '0;

    case ({push, pop})
      2'b10:   occ_nxt = occupancy + OCC_ONE;
      2'b01:   occ_nxt = occupancy - OCC_ONE;
      default: occ_nxt = occupancy;
    endcase

    if (pop) begin
      rd_nxt = rd_ptr + PTR_ONE;
    end

    // The incoming word becomes head when nothing else will be left in the FIFO.
    bypass = push && ((occupancy == '0) || ((occupancy == OCC_ONE) && pop));

    if (occ_nxt != '0) begin
      head_nxt = bypass ? wdata : mem[rd_nxt];
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk_user) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, fill level, counters and registered output stage.
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      rx_count  <= '0;
      tx_count  <= '0;
      dout_vld  <= 1'b0;
      dout      <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        rx_count <= rx_count + 32'd1;
      end
      if (pop) begin
        tx_count <= tx_count + 32'd1;
      end
      rd_ptr    <= rd_nxt;
      occupancy <= occ_nxt;
      dout_vld  <= (occ_nxt != '0);
      dout      <= head_nxt;
    end
  end

endmodule

// File: tb/tb_user_stream_endpoint.sv
// Bench for user_stream_endpoint: two instances (pass-through and +1) share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_user_stream_endpoint;

  logic        clk_user = 1'b0;
  logic        reset_n  = 1'b0;
  logic [31:0] din      = '0;
  logic        din_vld  = 1'b0;
  logic        dout_ack = 1'b0;

  logic        din_ack0, dout_vld0, din_ack1, dout_vld1;
  logic [31:0] dout0, dout1, rx0, tx0, rx1, tx1;
  logic [4:0]  occ0, occ1;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] q[$];
  logic [31:0] m_rx = '0;
  logic [31:0] m_tx = '0;
  int          popped = 0;
  bit          last_push;

  always #5 clk_user = ~clk_user;

  user_stream_endpoint #(.PAYLOAD_BITS(32), .FIFO_ADDR_BITS(4), .OP_MODE(0), .ADD_VAL(1)) u_dut0 (
    .clk_user(clk_user), .reset_n(reset_n), .din(din), .din_vld(din_vld), .din_ack(din_ack0),
    .dout(dout0), .dout_vld(dout_vld0), .dout_ack(dout_ack), .rx_count(rx0), .tx_count(tx0),
    .occupancy(occ0));

  user_stream_endpoint #(.PAYLOAD_BITS(32), .FIFO_ADDR_BITS(4), .OP_MODE(1), .ADD_VAL(1)) u_dut1 (
    .clk_user(clk_user), .reset_n(reset_n), .din(din), .din_vld(din_vld), .din_ack(din_ack1),
    .dout(dout1), .dout_vld(dout_vld1), .dout_ack(dout_ack), .rx_count(rx1), .tx_count(tx1),
    .occupancy(occ1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs follow directly from the model queue contents.
  task automatic compare_all();
    logic        exp_ack;
    logic        exp_vld;
    exp_ack = reset_n && (q.size() != 16);
    exp_vld = (q.size() != 0);
    check("din_ack0", 32'(din_ack0), 32'(exp_ack));
    check("din_ack1", 32'(din_ack1), 32'(exp_ack));
    check("dout_vld0", 32'(dout_vld0), 32'(exp_vld));
    check("dout_vld1", 32'(dout_vld1), 32'(exp_vld));
    check("occ0", 32'(occ0), 32'(q.size()));
    check("occ1", 32'(occ1), 32'(q.size()));
    check("rx0", rx0, m_rx);
    check("tx0", tx0, m_tx);
    check("rx1", rx1, m_rx);
    check("tx1", tx1, m_tx);
    if (exp_vld) begin
      check("dout0", dout0, q[0]);
      check("dout1", dout1, q[0] + 32'd1);
    end else if (!reset_n) begin
      check("dout0_rst", dout0, 32'd0);
      check("dout1_rst", dout1, 32'd0);
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, return 1 time unit later.
  task automatic cycle();
    bit push;
    bit pop;
    @(negedge clk_user);
    compare_all();
    push = din_vld && reset_n && (q.size() != 16);
    pop  = dout_ack && reset_n && (q.size() != 0);
    @(posedge clk_user);
    if (pop) begin
      void'(q.pop_front());
      m_tx++;
      popped++;
    end
    if (push) begin
      q.push_back(din);
      m_rx++;
    end
    last_push = push;
    #1;
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    q.delete();
    m_rx = '0;
    m_tx = '0;
    #1;
    check("rst_async_vld0", 32'(dout_vld0), 32'd0);
    check("rst_async_ack0", 32'(din_ack0), 32'd0);
    check("rst_async_occ0", 32'(occ0), 32'd0);
    check("rst_async_rx0", rx0, 32'd0);
    check("rst_async_tx0", tx0, 32'd0);
  endtask

  initial begin
    int idx;
    int exp_out;
    int guard;

    // Reset held with din_vld asserted: nothing may be accepted.
    din_vld = 1'b1;
    din     = 32'h1234_5678;
    repeat (3) cycle();
    check("rst_rx", rx0, 32'd0);

    // Single word through the pass-through instance.
    reset_n  = 1'b1;
    din      = 32'hDEAD_BEEF;
    din_vld  = 1'b1;
    dout_ack = 1'b1;
    cycle();
    din_vld = 1'b0;
    check("single_dout", dout0, 32'hDEAD_BEEF);
    check("single_vld", 32'(dout_vld0), 32'd1);
    cycle();
    check("single_tx", tx0, 32'd1);
    cycle();

    // Fill with 20 offered words while output is stalled.
    dout_ack = 1'b0;
    din_vld  = 1'b1;
    idx      = 0;
    repeat (20) begin
      din = 32'(idx);
      cycle();
      if (last_push) idx++;
    end
    check("fill_accepted", 32'(idx), 32'd16);
    check("fill_occ", 32'(occ0), 32'd16);
    check("fill_ack", 32'(din_ack0), 32'd0);

    dout_ack = 1'b1;
    exp_out  = 0;
    guard    = 0;
    while (exp_out < 20 && guard < 200) begin
      din     = 32'(idx);
      din_vld = (idx < 20);
      if (dout_vld0) begin
        check("fill_order", dout0, 32'(exp_out));
        exp_out++;
      end
      cycle();
      if (last_push) idx++;
      guard++;
    end
    check("fill_drained", 32'(exp_out), 32'd20);
    din_vld = 1'b0;
    cycle();

    // Back-to-back streaming.
    din_vld  = 1'b1;
    dout_ack = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      din = 32'h1000_0000 + 32'(i);
      cycle();
      check("stream_occ_le1", 32'(occ0 <= 5'd1), 32'd1);
      check("stream_diff_le1", 32'((rx0 - tx0) <= 32'd1), 32'd1);
    end
    din_vld = 1'b0;
    cycle();
    cycle();

    // Add-mode wrap and simple increment on the second instance.
    din     = 32'hFFFF_FFFF;
    din_vld = 1'b1;
    cycle();
    din_vld = 1'b0;
    check("op1_wrap", dout1, 32'h0000_0000);
    check("op1_wrap_vld", 32'(dout_vld1), 32'd1);
    cycle();
    din     = 32'd5;
    din_vld = 1'b1;
    cycle();
    din_vld = 1'b0;
    check("op1_inc", dout1, 32'd6);
    cycle();
    cycle();

    // Random stalls with a reset pulse in the middle of the stream.
    popped = 0;
    guard  = 0;
    while (popped < 10000 && guard < 60000) begin
      din      = $urandom;
      din_vld  = ($urandom_range(0, 3) != 0);
      dout_ack = ($urandom_range(0, 3) != 0);
      if (guard == 3000) begin
        din_vld  = 1'b1;
        dout_ack = 1'b0;
        assert_reset();
        cycle();
        cycle();
        reset_n = 1'b1;
        check("mid_rst_occ", 32'(occ0), 32'd0);
        check("mid_rst_rx", rx0, 32'd0);
        check("mid_rst_tx", tx0, 32'd0);
        cycle();
        check("mid_rst_first_accept", rx0, 32'd1);
      end else begin
        cycle();
      end
      guard++;
    end
    check("random_done", 32'(popped >= 10000), 32'd1);
    din_vld  = 1'b0;
    dout_ack = 1'b1;
    repeat (20) cycle();
    check("final_empty", 32'(occ0), 32'd0);
    check("final_balance", rx0 - tx0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
